// File: rtl/note_draw_sched_if.sv
// Event-in / draw-out bundle between the key decoder, note_draw_sched and the glyph drawer.
// master drives note events; slave is the scheduler.
interface note_draw_sched_if;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       note_valid;
    logic [3:0] note;
    logic [1:0] octave;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_in;
    logic       ld_note;
    logic       busy;
    logic       drop;

    modport master (
        output note_in, octave_in, note_valid,
        input  note, octave, x, y, colour_in, ld_note, busy, drop
    );

    modport slave (
        input  note_in, octave_in, note_valid,
        output note, octave, x, y, colour_in, ld_note, busy, drop
    );
endinterface

// File: rtl/note_draw_sched.sv
// Note event FIFO + draw scheduler: one glyph load per DRAW_CYCLES+3 cycles, four wrapping slots.
// Optional macro NOTE_SCHED_OCT_COLOUR_EN: colour derived from the octave instead of COLOUR.
module note_draw_sched #(
    parameter int         DEPTH       = 4,
    parameter int         DRAW_CYCLES = 1024,
    parameter int         X_BASE      = 4,
    parameter int         Y_BASE      = 8,
    parameter int         ROW_PITCH   = 16,
    parameter logic [2:0] COLOUR      = 3'b111
) (
    input  logic              clk,
    input  logic              reset,
    note_draw_sched_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] octave;
    } evt_t;

    typedef enum logic [1:0] {IDLE, SETUP, LOAD, WAIT} state_t;

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    logic [15:0]   wait_cnt;
    logic [1:0]    slot;

    logic       note_ok, full, empty, pop, push, reject;
    evt_t       head;
    logic [6:0] slot_y;
    logic [2:0] pop_colour;

    assign note_ok = (bus.note_in != 4'd0) && (bus.note_in <= 4'd12);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = (state == IDLE) && !empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push    = bus.note_valid && note_ok && (!full || pop);
    assign reject  = bus.note_valid && !push;
    assign head    = mem[rd_ptr];
    assign slot_y  = 7'(Y_BASE) + 7'(ROW_PITCH) * {5'd0, slot};

`ifdef NOTE_SCHED_OCT_COLOUR_EN
    always_comb begin
        pop_colour = 3'b001;
        case (head.octave)
            2'd0:    pop_colour = 3'b001;
            2'd1:    pop_colour = 3'b010;
            2'd2:    pop_colour = 3'b100;
            default: pop_colour = 3'b110;
        endcase
    end
`else
    assign pop_colour = COLOUR;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{note: bus.note_in, octave: bus.octave_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bus.drop <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            bus.drop <= reject;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            slot          <= 2'd0;
            wait_cnt      <= '0;
            bus.note      <= 4'd0;
            bus.octave    <= 2'd0;
            bus.x         <= 8'(X_BASE);
            bus.y         <= 7'(Y_BASE);
            bus.colour_in <= 3'b000;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    bus.note      <= head.note;
                    bus.octave    <= head.octave;
                    bus.x         <= 8'(X_BASE);
                    bus.y         <= slot_y;
                    bus.colour_in <= pop_colour;
                    state         <= SETUP;
                end
                SETUP: state <= LOAD;
                LOAD: begin
                    wait_cnt <= '0;
                    slot     <= slot + 2'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 16'(DRAW_CYCLES - 1)) state <= IDLE;
                    else wait_cnt <= wait_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ld_note = (state == LOAD);
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_note_draw_sched.sv
// Directed bench for note_draw_sched at default parameters (DEPTH=4, DRAW_CYCLES=1024).
module tb_note_draw_sched;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   drop_cnt = 0;
    int   ld_cyc[$];
    int   ld_y[$];
    int   ld_nt[$];
    int   ld_col[$];

    note_draw_sched_if bus();

    note_draw_sched dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ld_note === 1'b1) begin
            ld_cyc.push_back(cyc);
            ld_y.push_back(int'(bus.y));
            ld_nt.push_back(int'(bus.note));
            ld_col.push_back(int'(bus.colour_in));
        end
        if (bus.drop === 1'b1) drop_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.note_valid = 1'b0;
        bus.note_in = 4'd0;
        bus.octave_in = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ld_cyc.delete(); ld_y.delete(); ld_nt.delete(); ld_col.delete();
        drop_cnt = 0;
    endtask

    // Call just after a negedge; returns at the negedge after the strobe edge.
    task automatic send(input logic [3:0] n, input logic [1:0] o);
        bus.note_valid = 1'b1;
        bus.note_in = n;
        bus.octave_in = o;
        @(negedge clk);
        bus.note_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (bus.note !== 4'd0) $display("FAIL rst_note got %0d want 0", bus.note); else n_pass++;
        n_total++; if (bus.octave !== 2'd0) $display("FAIL rst_octave got %0d want 0", bus.octave); else n_pass++;
        n_total++; if (bus.x !== 8'd4) $display("FAIL rst_x got %0d want 4", bus.x); else n_pass++;
        n_total++; if (bus.y !== 7'd8) $display("FAIL rst_y got %0d want 8", bus.y); else n_pass++;
        n_total++; if (bus.colour_in !== 3'd0) $display("FAIL rst_colour got %0d want 0", bus.colour_in); else n_pass++;
        n_total++; if (bus.ld_note !== 1'b0) $display("FAIL rst_ld got %b want 0", bus.ld_note); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.drop !== 1'b0) $display("FAIL rst_drop got %b want 0", bus.drop); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        send(4'd4, 2'd1);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL single_busy_E got %b want 0", bus.busy); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.note !== 4'd4) $display("FAIL single_note got %0d want 4", bus.note); else n_pass++;
        n_total++; if (bus.octave !== 2'd1) $display("FAIL single_octave got %0d want 1", bus.octave); else n_pass++;
        n_total++; if (bus.x !== 8'd4) $display("FAIL single_x got %0d want 4", bus.x); else n_pass++;
        n_total++; if (bus.y !== 7'd8) $display("FAIL single_y got %0d want 8", bus.y); else n_pass++;
        n_total++; if (bus.colour_in !== 3'b111 && bus.colour_in !== 3'b010) $display("FAIL single_colour got %0d want 7 or 2", bus.colour_in); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL single_busy_E1 got %b want 1", bus.busy); else n_pass++;
        n_total++; if (bus.ld_note !== 1'b0) $display("FAIL single_ld_E1 got %b want 0", bus.ld_note); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.ld_note !== 1'b1) $display("FAIL single_ld_E2 got %b want 1", bus.ld_note); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.ld_note !== 1'b0) $display("FAIL single_ld_E3 got %b want 0", bus.ld_note); else n_pass++;
        repeat (1023) @(negedge clk);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL single_busy_last_wait got %b want 1", bus.busy); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", bus.busy); else n_pass++;
        n_total++; if (ld_cyc.size() != 1) $display("FAIL single_ld_count got %0d want 1", ld_cyc.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ey[5] = '{8, 24, 40, 56, 8};
        do_reset();
        for (int i = 1; i <= 5; i++) send(4'(i), 2'd0);
        repeat (5 * 1027 + 20) @(negedge clk);
        n_total++; if (drop_cnt != 0) $display("FAIL b2b_drop got %0d want 0", drop_cnt); else n_pass++;
        n_total++;
        if (ld_cyc.size() != 5) $display("FAIL b2b_ld_count got %0d want 5", ld_cyc.size());
        else begin
            n_pass++;
            for (int i = 0; i < 5; i++) begin
                n_total++; if (ld_y[i] != ey[i]) $display("FAIL b2b_y[%0d] got %0d want %0d", i, ld_y[i], ey[i]); else n_pass++;
                n_total++; if (ld_nt[i] != i + 1) $display("FAIL b2b_note[%0d] got %0d want %0d", i, ld_nt[i], i + 1); else n_pass++;
                if (i > 0) begin
                    n_total++; if (ld_cyc[i] - ld_cyc[i-1] != 1027) $display("FAIL b2b_gap[%0d] got %0d want 1027", i, ld_cyc[i] - ld_cyc[i-1]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) send(4'(i), 2'd0);
        n_total++; if (bus.drop !== 1'b0) $display("FAIL ovf_drop_early got %b want 0", bus.drop); else n_pass++;
        send(4'd6, 2'd0);
        n_total++; if (bus.drop !== 1'b1) $display("FAIL ovf_drop_pulse got %b want 1", bus.drop); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.drop !== 1'b0) $display("FAIL ovf_drop_clear got %b want 0", bus.drop); else n_pass++;
        repeat (6 * 1027 + 20) @(negedge clk);
        n_total++; if (drop_cnt != 1) $display("FAIL ovf_drop_count got %0d want 1", drop_cnt); else n_pass++;
        n_total++; if (ld_cyc.size() != 5) $display("FAIL ovf_draws got %0d want 5", ld_cyc.size()); else n_pass++;
        n_total++; if (ld_nt.size() == 5 && ld_nt[4] != 5) $display("FAIL ovf_last_note got %0d want 5", ld_nt[4]); else n_pass++;
    endtask

    task automatic test_invalid();
        do_reset();
        send(4'd0, 2'd0);
        send(4'd13, 2'd0);
        repeat (10) @(negedge clk);
        n_total++; if (drop_cnt != 2) $display("FAIL inv_drop_count got %0d want 2", drop_cnt); else n_pass++;
        n_total++; if (ld_cyc.size() != 0) $display("FAIL inv_ld_count got %0d want 0", ld_cyc.size()); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL inv_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_reset_mid_draw();
        do_reset();
        for (int i = 1; i <= 3; i++) send(4'(i), 2'd0);
        repeat (50) @(negedge clk);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_wait got %b want 1", bus.busy); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_busy_rst got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.ld_note !== 1'b0) $display("FAIL mid_ld_rst got %b want 0", bus.ld_note); else n_pass++;
        reset = 1'b0;
        ld_cyc.delete(); ld_y.delete(); ld_nt.delete(); ld_col.delete();
        repeat (1100) @(negedge clk);
        n_total++; if (ld_cyc.size() != 0) $display("FAIL mid_no_ld got %0d want 0", ld_cyc.size()); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_idle got %b want 0", bus.busy); else n_pass++;
        send(4'd7, 2'd2);
        repeat (3) @(negedge clk);
        n_total++; if (bus.y !== 7'd8) $display("FAIL mid_new_y got %0d want 8", bus.y); else n_pass++;
        n_total++; if (bus.note !== 4'd7) $display("FAIL mid_new_note got %0d want 7", bus.note); else n_pass++;
        n_total++; if (ld_cyc.size() != 1) $display("FAIL mid_new_ld got %0d want 1", ld_cyc.size()); else n_pass++;
    endtask

    task automatic test_colour();
        int ec[4];
`ifdef NOTE_SCHED_OCT_COLOUR_EN
        ec = '{1, 2, 4, 6};
`else
        ec = '{7, 7, 7, 7};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) send(4'd1, 2'(i));
        repeat (4 * 1027 + 20) @(negedge clk);
        n_total++;
        if (ld_col.size() != 4) $display("FAIL col_draws got %0d want 4", ld_col.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_total++; if (ld_col[i] != ec[i]) $display("FAIL col[%0d] got %0d want %0d", i, ld_col[i], ec[i]); else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.note_valid = 1'b0;
        bus.note_in = 4'd0;
        bus.octave_in = 2'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_invalid();
        test_reset_mid_draw();
        test_colour();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
